lpc_frame_sched: RTL and testbench
==================================

Name: lpc_frame_sched

Overview:
- Frame scheduler and configurator for the LPC decoder datapath.
- Accepts coded frames from upstream over a valid/ready handshake: voiced flag, pitch period and 11 predictor coefficients.
- Double-buffers frames and generates the decoder's sample strobe `v` at a fixed clock division.
- Keeps the decoder's coefficient/excitation configuration stable for exactly FRAME_LEN samples, then swaps to the next frame on a sample boundary.

Parameters:
- CLK_DIV, 16, clocks per output sample; `v` pulses once every CLK_DIV cycles; legal range >= 2.
- FRAME_LEN, 160, samples per LPC frame; drives `lpcrate`; legal range >= 1.
- CW, 16, coefficient and pitch width.

Ports:
- clk  in  1  system clock
- rst  in  1  reset; asynchronous, active-high
- enable  in  1  run request; low forces IDLE
- frm_valid  in  1  upstream frame valid
- frm_ready  out  1  scheduler can accept a frame
- frm_voiced  in  1  frame voiced flag
- frm_pitch  in  CW  pitch period in samples
- frm_coef  in  11*CW  A0..A10 packed, A0 in bits [CW-1:0]; signed
- v  out  1  sample strobe to decoder, one cycle wide
- voiced  out  1  active-frame voiced flag
- pulserate  out  CW  active-frame pitch
- lpcrate  out  CW  constant FRAME_LEN
- coef  out  11*CW  active-frame A0..A10, same packing
- frame_start  out  1  one-cycle pulse when a new frame becomes active
- underrun  out  1  sticky; set on a boundary with no pending frame; cleared by rst or entering IDLE
- active  out  1  high in RUN

Behaviour:
- Reset state: all outputs 0 except `lpcrate` = FRAME_LEN. State = IDLE; both buffers empty; counters 0.
- Storage:
  - `act` register drives voiced/pulserate/coef.
  - `pend` register holds one waiting frame plus `pend_v`.
  - frm_ready = (state != IDLE) && !pend_v.
  - Accept = frm_valid && frm_ready.
- IDLE:
  - v = 0; counters held at 0; pend_v cleared; act outputs hold last values.
  - enable = 1 -> WAIT_FIRST.
- WAIT_FIRST:
  - frm_ready = 1.
  - On accept, the frame loads directly into act; frame_start = 1 next cycle; go RUN; div = 0, smp = 0.
  - enable = 0 -> IDLE.
- RUN:
  - div counts 0..CLK_DIV-1 and wraps.
  - v is registered, high in the cycle after div = CLK_DIV-1. The first v occurs CLK_DIV cycles after entry to RUN.
  - smp increments on each v and wraps at FRAME_LEN-1.
  - Boundary = the v cycle where smp = FRAME_LEN-1.
  - At a boundary, if pend_v: pend -> act; pend_v <= 0; frame_start pulses in the same cycle the new act values appear. The next v uses the new frame.
  - At a boundary, if !pend_v: act retained (last frame repeats); underrun <= 1; no frame_start.
  - Accepts in RUN write pend (pend_v <= 1).
- Simultaneous events:
  - Accept and boundary in the same cycle with pend empty: the boundary sees empty (underrun). The frame lands in pend and is used at the next boundary. No bypass.
  - Boundary with pend full: ready is already low, so no accept that cycle. Ready rises the following cycle.
- enable falling in RUN: next cycle enters IDLE; the in-flight v is not issued; pend discarded; underrun cleared.
- rst mid-operation: immediate return to reset state regardless of handshake.
- Arithmetic:
  - Counters are $clog2(CLK_DIV) and $clog2(FRAME_LEN) bits; compare-to-terminal, no overflow.
  - Coefficients pass through unmodified. No sign manipulation.

Decomposition:
- Shared package `lpc_pkg`:
  - NCOEF = 11, CW default.
  - State enum {IDLE, WAIT_FIRST, RUN}.
  - Packed frame struct {voiced, pitch, coef[NCOEF]}.
- Sub-module `lpc_rate_gen`: divider plus sample counter, with outputs `v` and `boundary`.
- The FSM and buffers stay in the top module.

Test Plan (CLK_DIV = 4, FRAME_LEN = 3):
- Basic run: rst, enable = 1, frame F1 (voiced = 1, pitch = 40, A0 = 0x1000) -> accepted in 1 cycle, frame_start 1 cycle later. v at cycles +4, +8, +12. pulserate = 40, coef A0 = 0x1000 throughout.
- Swap: F2 (pitch = 80) offered during F1 -> frm_ready drops after accept. On the 3rd v, pulserate = 80 and frame_start pulses. The 4th v uses F2. frm_ready re-asserts next cycle.
- Underrun: no second frame -> at the 3rd v underrun = 1, F1 values retained, no frame_start. A frame then supplied is used at the 6th v; underrun stays 1.
- Backpressure: frm_valid held high with F2, F3 -> F3 waits with ready = 0 until the F2 swap, then is accepted. No frame dropped or duplicated; frame order matches the checker.
- Simultaneous: frm_valid asserted exactly on a boundary cycle with pend empty -> underrun set; frame appears at the next boundary.
- Abort: enable = 0 mid-frame -> v stops next cycle, active = 0, underrun = 0, pend cleared. Asserting rst async mid-cycle -> all outputs 0 immediately, lpcrate = 3.

Source files
------------

// File: rtl/lpc_pkg.sv
// Shared types for the LPC frame scheduler: coefficient count, FSM states and
// the packed frame record exchanged between upstream, pend and act buffers.
package lpc_pkg;

   localparam int NCOEF = 11;
   localparam int CW    = 16;

   typedef enum logic [1:0] {
      IDLE,
      WAIT_FIRST,
      RUN
   } state_t;

   // coef[0] sits in the low bits so the struct matches the A0-first port packing.
   typedef struct packed {
      logic                       voiced;
      logic [CW-1:0]              pitch;
      logic [NCOEF-1:0][CW-1:0]   coef;
   } frame_t;

endpackage

// File: rtl/lpc_frame_sched_rate_gen.sv
// Sample strobe generator: clock divider plus per-frame sample counter.
// Counters sit at zero whenever run is low, so RUN always starts phase-aligned.
module lpc_rate_gen #(
   parameter int CLK_DIV   = 16,
   parameter int FRAME_LEN = 160
) (
   input  logic clk,
   input  logic rst,
   input  logic run,
   output logic v,
   output logic boundary
);

   localparam int DW = $clog2(CLK_DIV);
   localparam int SW = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
   localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
   localparam logic [SW-1:0] SMP_LAST = SW'(FRAME_LEN - 1);

   logic [DW-1:0] div;
   logic [SW-1:0] smp;

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values of its neighbours, independent of statement order.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         div <= '0;
         smp <= '0;
         v   <= 1'b0;
      end else if (!run) begin
         div <= '0;
         smp <= '0;
         v   <= 1'b0;
      end else begin
         v   <= (div == DIV_LAST);
         div <= (div == DIV_LAST) ? '0 : div + 1'b1;
         if (v)
            smp <= (smp == SMP_LAST) ? '0 : smp + 1'b1;
      end
   end

   assign boundary = v && (smp == SMP_LAST);

endmodule

// File: rtl/lpc_frame_sched.sv
// LPC frame scheduler: double-buffers upstream frames and holds the decoder
// configuration stable for FRAME_LEN samples, swapping only on frame boundaries.
module lpc_frame_sched
   import lpc_pkg::*;
#(
   parameter int CLK_DIV   = 16,
   parameter int FRAME_LEN = 160,
   parameter int CW        = lpc_pkg::CW
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                enable,
   input  logic                frm_valid,
   output logic                frm_ready,
   input  logic                frm_voiced,
   input  logic [CW-1:0]       frm_pitch,
   input  logic [NCOEF*CW-1:0] frm_coef,
   output logic                v,
   output logic                voiced,
   output logic [CW-1:0]       pulserate,
   output logic [CW-1:0]       lpcrate,
   output logic [NCOEF*CW-1:0] coef,
   output logic                frame_start,
   output logic                underrun,
   output logic                active
);

   state_t state_q, state_d;
   frame_t in_frm, act, pend;
   logic   pend_v;
   logic   accept, load_first, swap, boundary, run;

   assign in_frm    = {frm_voiced, frm_pitch, frm_coef};
   assign frm_ready = (state_q != IDLE) && !pend_v;
   assign accept    = frm_valid && frm_ready;
   assign run       = (state_q == RUN) && enable;
   assign active    = (state_q == RUN);

   lpc_rate_gen #(
      .CLK_DIV   (CLK_DIV),
      .FRAME_LEN (FRAME_LEN)
   ) u_rate (
      .clk      (clk),
      .rst      (rst),
      .run      (run),
      .v        (v),
      .boundary (boundary)
   );

   // NOTE: every always_comb output gets a default first, so no path can
   // leave a value unassigned and infer a latch.
   always_comb begin
      state_d    = state_q;
      load_first = 1'b0;
      swap       = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (enable)
               state_d = WAIT_FIRST;
         end
         WAIT_FIRST: begin
            if (!enable) begin
               state_d = IDLE;
            end else if (accept) begin
               state_d    = RUN;
               load_first = 1'b1;
            end
         end
         RUN: begin
            if (!enable)
               state_d = IDLE;
            else if (boundary && pend_v)
               swap = 1'b1;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   // A frame accepted on a boundary lands in pend only; the boundary saw it empty.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         act         <= '0;
         pend        <= '0;
         pend_v      <= 1'b0;
         frame_start <= 1'b0;
         underrun    <= 1'b0;
      end else begin
         frame_start <= load_first || swap;
         if (load_first)
            act <= in_frm;
         else if (swap)
            act <= pend;

         if (state_d == IDLE) begin
            pend_v   <= 1'b0;
            underrun <= 1'b0;
         end else begin
            if (swap)
               pend_v <= 1'b0;
            if (accept && state_q == RUN) begin
               pend   <= in_frm;
               pend_v <= 1'b1;
            end
            if (run && boundary && !pend_v)
               underrun <= 1'b1;
         end
      end
   end

   assign voiced    = act.voiced;
   assign pulserate = act.pitch;
   assign coef      = act.coef;
   assign lpcrate   = CW'(FRAME_LEN);

endmodule

// File: tb/tb_lpc_frame_sched.sv
// Self-checking bench for lpc_frame_sched: directed phases plus random traffic
// compared cycle by cycle against a sample-index reference model.
module tb_lpc_frame_sched;
   import lpc_pkg::*;

   localparam int CD = 4;
   localparam int FL = 3;

   logic                clk = 1'b0;
   logic                rst;
   logic                enable, frm_valid, frm_ready, frm_voiced;
   logic [CW-1:0]       frm_pitch, pulserate, lpcrate;
   logic [NCOEF*CW-1:0] frm_coef, coef;
   logic                v, voiced, frame_start, underrun, active;

   lpc_frame_sched #(.CLK_DIV(CD), .FRAME_LEN(FL), .CW(CW)) dut (
      .clk         (clk),
      .rst         (rst),
      .enable      (enable),
      .frm_valid   (frm_valid),
      .frm_ready   (frm_ready),
      .frm_voiced  (frm_voiced),
      .frm_pitch   (frm_pitch),
      .frm_coef    (frm_coef),
      .v           (v),
      .voiced      (voiced),
      .pulserate   (pulserate),
      .lpcrate     (lpcrate),
      .coef        (coef),
      .frame_start (frame_start),
      .underrun    (underrun),
      .active      (active)
   );

   always #5 clk = ~clk;

   int tests_run    = 0;
   int tests_failed = 0;

   task automatic chk(input string tag, input logic [191:0] obs, input logic [191:0] exp);
      tests_run++;
      assert (obs === exp) else begin
         tests_failed++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Reference model: time in RUN counted in clocks; samples and frames derived by division.
   localparam int M_IDLE = 0, M_WAIT = 1, M_RUN = 2;
   int     m_mode, m_k;
   frame_t m_act;
   frame_t m_pend[$];
   bit     m_fs, m_ur;

   function automatic bit m_v();
      return (m_mode == M_RUN) && (m_k > 0) && (m_k % CD == 0);
   endfunction

   function automatic bit m_bnd();
      return m_v() && ((m_k / CD) % FL == 0);
   endfunction

   function automatic bit m_ready();
      return (m_mode != M_IDLE) && (m_pend.size() == 0);
   endfunction

   task automatic model_reset();
      m_mode = M_IDLE;
      m_k    = 0;
      m_act  = '0;
      m_pend.delete();
      m_fs   = 0;
      m_ur   = 0;
   endtask

   task automatic model_edge(input bit en, input bit fv, input frame_t f);
      bit acc = fv && m_ready();
      bit bnd = m_bnd();
      m_fs = 0;
      case (m_mode)
         M_IDLE: if (en) m_mode = M_WAIT;
         M_WAIT: begin
            if (!en) m_mode = M_IDLE;
            else if (acc) begin
               m_act  = f;
               m_fs   = 1;
               m_mode = M_RUN;
               m_k    = 0;
            end
         end
         default: begin
            if (!en) m_mode = M_IDLE;
            else begin
               if (bnd) begin
                  if (m_pend.size() > 0) begin
                     m_act = m_pend.pop_front();
                     m_fs  = 1;
                  end else begin
                     m_ur = 1;
                  end
               end
               if (acc) m_pend.push_back(f);
               m_k++;
            end
         end
      endcase
      if (m_mode == M_IDLE) begin
         m_pend.delete();
         m_ur = 0;
         m_k  = 0;
      end
   endtask

   task automatic check_outputs();
      chk("v",           v,           m_v());
      chk("frame_start", frame_start, m_fs);
      chk("active",      active,      m_mode == M_RUN);
      chk("underrun",    underrun,    m_ur);
      chk("frm_ready",   frm_ready,   m_ready());
      chk("voiced",      voiced,      m_act.voiced);
      chk("pulserate",   pulserate,   m_act.pitch);
      chk("coef",        coef,        m_act.coef);
      chk("lpcrate",     lpcrate,     FL);
   endtask

   task automatic cyc(input bit en, input bit fv, input frame_t f, output bit acc);
      enable    = en;
      frm_valid = fv;
      {frm_voiced, frm_pitch, frm_coef} = f;
      acc = fv && m_ready();
      @(posedge clk);
      model_edge(en, fv, f);
      #1;
      check_outputs();
   endtask

   function automatic frame_t rand_frame(input logic [CW-1:0] pitch, input logic [CW-1:0] a0);
      frame_t f;
      f.voiced = 1'($urandom % 2);
      f.pitch  = pitch;
      for (int i = 0; i < NCOEF; i++) f.coef[i] = CW'($urandom);
      f.coef[0] = a0;
      return f;
   endfunction

   task automatic idle_n(input int n);
      bit acc;
      repeat (n) cyc(1'b1, 1'b0, rand_frame(CW'($urandom), CW'($urandom)), acc);
   endtask

   task automatic offer(input frame_t f, input string tag);
      bit acc = 0;
      for (int i = 0; i < 60 && !acc; i++) cyc(1'b1, 1'b1, f, acc);
      if (!acc) chk({tag, "_accept_timeout"}, 0, 1);
   endtask

   initial begin
      frame_t f;
      bit     acc, found;

      rst        = 1'b1;
      enable     = 1'b0;
      frm_valid  = 1'b0;
      frm_voiced = 1'b0;
      frm_pitch  = '0;
      frm_coef   = '0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check_outputs();
      rst = 1'b0;

      // Basic run with F1, then swap to F2.
      cyc(1'b1, 1'b0, '0, acc);
      f = rand_frame(40, 16'h1000);
      f.voiced = 1'b1;
      offer(f, "f1");
      idle_n(5);
      offer(rand_frame(80, CW'($urandom)), "f2");
      idle_n(12);

      // Underrun: starve two boundaries, then supply one frame.
      idle_n(30);
      offer(rand_frame(CW'($urandom), CW'($urandom)), "late");
      idle_n(16);

      // Abort mid-frame with pend full.
      offer(rand_frame(CW'($urandom), CW'($urandom)), "pend");
      idle_n(2);
      cyc(1'b0, 1'b0, '0, acc);
      chk("abort_active",   active,    0);
      chk("abort_underrun", underrun,  0);
      chk("abort_v",        v,         0);
      cyc(1'b0, 1'b0, '0, acc);

      // Restart, then offer a frame exactly on a boundary with pend empty.
      cyc(1'b1, 1'b0, '0, acc);
      offer(rand_frame(CW'($urandom), CW'($urandom)), "restart");
      found = 0;
      for (int i = 0; i < 100 && !found; i++) begin
         if (m_bnd() && m_pend.size() == 0) found = 1;
         else idle_n(1);
      end
      if (!found) chk("sim_boundary_timeout", 0, 1);
      cyc(1'b1, 1'b1, rand_frame(CW'($urandom), CW'($urandom)), acc);
      chk("sim_underrun",    underrun,    1);
      chk("sim_no_start",    frame_start, 0);
      idle_n(14);

      // Backpressure: valid held high across consecutive frames.
      offer(rand_frame(100, CW'($urandom)), "bp_a");
      offer(rand_frame(200, CW'($urandom)), "bp_b");
      offer(rand_frame(300, CW'($urandom)), "bp_c");
      idle_n(14);

      // Random traffic with occasional enable drops.
      repeat (400) begin
         cyc(1'(($urandom % 50) != 0), 1'($urandom % 2),
             rand_frame(CW'($urandom), CW'($urandom)), acc);
      end

      // Asynchronous reset mid-cycle while running.
      cyc(1'b1, 1'b0, '0, acc);
      cyc(1'b1, 1'b0, '0, acc);
      offer(rand_frame(CW'($urandom), CW'($urandom)), "pre_rst");
      idle_n(6);
      chk("pre_rst_active", active, 1);
      #2;
      rst = 1'b1;
      #1;
      chk("rst_v",           v,           0);
      chk("rst_active",      active,      0);
      chk("rst_ready",       frm_ready,   0);
      chk("rst_voiced",      voiced,      0);
      chk("rst_pulserate",   pulserate,   0);
      chk("rst_coef",        coef,        0);
      chk("rst_frame_start", frame_start, 0);
      chk("rst_underrun",    underrun,    0);
      chk("rst_lpcrate",     lpcrate,     FL);
      model_reset();
      @(posedge clk);
      #1;
      rst = 1'b0;
      cyc(1'b0, 1'b0, '0, acc);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
